// File: rtl/dpc_pkg.sv
// Shared types, constants and instruction field offsets for the
// pipelined datapath decode/issue controller.
package dpc_pkg;

   typedef enum logic [1:0] {
      OP_RST_RF  = 2'b00,
      OP_LOAD    = 2'b01,
      OP_STORE   = 2'b10,
      OP_RST_MEM = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      BR_EQ   = 2'b00,
      BR_GT   = 2'b01,
      BR_LT   = 2'b10,
      BR_NONE = 2'b11
   } br_e;

   localparam logic [1:0] CMP_EQ   = 2'b00;
   localparam logic [1:0] CMP_GT   = 2'b10;
   localparam logic [1:0] CMP_LT   = 2'b01;
   localparam logic [1:0] COMP_CMP = 2'b10;

   typedef enum logic {
      ST_ISSUE   = 1'b0,
      ST_WAIT_BR = 1'b1
   } state_e;

   // Field LSB positions, MSB first: op, selA, selB, comp, br, target, srcA, srcB, imm
   function automatic int instr_w(int r, int i);   return 8 + 3*r + i; endfunction
   function automatic int op_lsb(int r, int i);    return 6 + 3*r + i; endfunction
   function automatic int sela_pos(int r, int i);  return 5 + 3*r + i; endfunction
   function automatic int selb_pos(int r, int i);  return 4 + 3*r + i; endfunction
   function automatic int comp_lsb(int r, int i);  return 2 + 3*r + i; endfunction
   function automatic int br_lsb(int r, int i);    return 3*r + i;     endfunction
   function automatic int tgt_lsb(int r, int i);   return 2*r + i;     endfunction
   function automatic int srca_lsb(int r, int i);  return r + i;       endfunction

   // cmp = 11 matches no condition, so it falls out as not taken
   function automatic logic br_taken(br_e br, logic [1:0] cmp);
      return ((br == BR_EQ) && (cmp == CMP_EQ)) ||
             ((br == BR_GT) && (cmp == CMP_GT)) ||
             ((br == BR_LT) && (cmp == CMP_LT));
   endfunction

endpackage

// File: rtl/dpc_if.sv
// Instruction / compare / control-bundle bus of the decode controller.
interface dpc_if #(
   parameter int REG_ADDR_W = 8,
   parameter int IMM_W      = 32
);
   localparam int INSTR_W = dpc_pkg::instr_w(REG_ADDR_W, IMM_W);

   logic                  instr_valid;
   logic [INSTR_W-1:0]    instr;
   logic                  instr_ready;
   logic                  cmp_valid;
   logic [1:0]            ALUCompare;
   logic                  ctrl_valid;
   logic                  resetRegisterFile;
   logic                  resetMemory;
   logic                  registerFileRead;
   logic                  registerFileWrite;
   logic                  memoryRead;
   logic                  memoryWrite;
   logic                  sourceSelectA;
   logic                  sourceSelectB;
   logic [1:0]            computationSelect;
   logic [REG_ADDR_W-1:0] target;
   logic [REG_ADDR_W-1:0] sourceA;
   logic [REG_ADDR_W-1:0] sourceB;
   logic [IMM_W-1:0]      immediate;
   logic                  PCChangeEnable;
   logic                  stall;

   modport master (
      output instr_valid, instr, cmp_valid, ALUCompare,
      input  instr_ready, ctrl_valid, resetRegisterFile, resetMemory,
             registerFileRead, registerFileWrite, memoryRead, memoryWrite,
             sourceSelectA, sourceSelectB, computationSelect,
             target, sourceA, sourceB, immediate, PCChangeEnable, stall
   );

   modport slave (
      input  instr_valid, instr, cmp_valid, ALUCompare,
      output instr_ready, ctrl_valid, resetRegisterFile, resetMemory,
             registerFileRead, registerFileWrite, memoryRead, memoryWrite,
             sourceSelectA, sourceSelectB, computationSelect,
             target, sourceA, sourceB, immediate, PCChangeEnable, stall
   );
endinterface

// File: rtl/dpc_scoreboard.sv
// In-flight register-write scoreboard: one {valid, target} entry per
// cycle of writeback latency, plus read-after-write match logic.
module dpc_scoreboard #(
   parameter int REG_ADDR_W = 8,
   parameter int WB_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid_i,
   input  logic [REG_ADDR_W-1:0] push_addr_i,
   input  logic                  flush_i,
   input  logic                  chk_a_i,
   input  logic [REG_ADDR_W-1:0] addr_a_i,
   input  logic                  chk_b_i,
   input  logic [REG_ADDR_W-1:0] addr_b_i,
   output logic                  hazard_o
);

   logic [WB_LATENCY-1:0] vld_q;
   logic [REG_ADDR_W-1:0] addr_q [WB_LATENCY];

   // Shift every cycle; bubbles enter as invalid, flush drops all older entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < WB_LATENCY; i++) addr_q[i] <= '0;
      end else begin
         vld_q[0]  <= push_valid_i && !flush_i;
         addr_q[0] <= push_addr_i;
         for (int i = 1; i < WB_LATENCY; i++) begin
            vld_q[i]  <= vld_q[i-1] && !flush_i;
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   // Register 0 is hard-wired, so reading it can never conflict
   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < WB_LATENCY; i++) begin
         if (vld_q[i]) begin
            if (chk_a_i && (addr_a_i != '0) && (addr_a_i == addr_q[i])) hazard_o = 1'b1;
            if (chk_b_i && (addr_b_i != '0) && (addr_b_i == addr_q[i])) hazard_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipelined_datapath_controller.sv
// Instruction decode / issue controller with registered control bundle,
// RAW hazard stall and branch resolution.
// Optional DPC_PERF_COUNT_EN: adds issued_count / stall_count outputs.
//
// state      | meaning
// ST_ISSUE   | accepting instructions unless a RAW hazard is pending
// ST_WAIT_BR | branch issued, holding issue until the ALU compare returns
module pipelined_datapath_controller
   import dpc_pkg::*;
#(
   parameter int REG_ADDR_W = 8,
   parameter int IMM_W      = 32,
   parameter int WB_LATENCY = 3
) (
   input logic clk,
   input logic reset,
   dpc_if.slave bus
`ifdef DPC_PERF_COUNT_EN
   ,
   output logic [31:0] issued_count,
   output logic [31:0] stall_count
`endif
);

   localparam int OP_LSB   = op_lsb(REG_ADDR_W, IMM_W);
   localparam int SELA_POS = sela_pos(REG_ADDR_W, IMM_W);
   localparam int SELB_POS = selb_pos(REG_ADDR_W, IMM_W);
   localparam int COMP_LSB = comp_lsb(REG_ADDR_W, IMM_W);
   localparam int BR_LSB   = br_lsb(REG_ADDR_W, IMM_W);
   localparam int TGT_LSB  = tgt_lsb(REG_ADDR_W, IMM_W);
   localparam int SRCA_LSB = srca_lsb(REG_ADDR_W, IMM_W);
   localparam int SRCB_LSB = IMM_W;

   op_e                   op_w;
   br_e                   br_w;
   logic                  sel_a_w, sel_b_w;
   logic [1:0]            comp_w;
   logic [REG_ADDR_W-1:0] tgt_w, src_a_w, src_b_w;

   assign op_w    = op_e'(bus.instr[OP_LSB +: 2]);
   assign sel_a_w = bus.instr[SELA_POS];
   assign sel_b_w = bus.instr[SELB_POS];
   assign comp_w  = bus.instr[COMP_LSB +: 2];
   assign br_w    = br_e'(bus.instr[BR_LSB +: 2]);
   assign tgt_w   = bus.instr[TGT_LSB +: REG_ADDR_W];
   assign src_a_w = bus.instr[SRCA_LSB +: REG_ADDR_W];
   assign src_b_w = bus.instr[SRCB_LSB +: REG_ADDR_W];

   state_e state_q, state_d;
   br_e    br_q, br_d;
   logic   pc_change_q, pc_change_d;
   logic   hazard_w, instr_ready_w, stall_w, accept_w;

   dpc_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .WB_LATENCY(WB_LATENCY)) u_sb (
      .clk          (clk),
      .rst          (reset),
      .push_valid_i (accept_w && (op_w == OP_LOAD)),
      .push_addr_i  (tgt_w),
      .flush_i      (accept_w && (op_w == OP_RST_RF)),
      .chk_a_i      (bus.instr_valid && !sel_a_w),
      .addr_a_i     (src_a_w),
      .chk_b_i      (bus.instr_valid && !sel_b_w),
      .addr_b_i     (src_b_w),
      .hazard_o     (hazard_w)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_ISSUE;
         br_q        <= BR_NONE;
         pc_change_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         br_q        <= br_d;
         pc_change_q <= pc_change_d;
      end
   end

   // Next state, handshake and stall; reset gates ready so outputs read 0 during reset
   always_comb begin
      state_d       = state_q;
      br_d          = br_q;
      pc_change_d   = 1'b0;
      instr_ready_w = 1'b0;
      stall_w       = 1'b0;
      accept_w      = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            instr_ready_w = !hazard_w && !reset;
            stall_w       = hazard_w;
            accept_w      = bus.instr_valid && instr_ready_w;
            if (accept_w && (br_w != BR_NONE)) begin
               state_d = ST_WAIT_BR;
               br_d    = br_w;
            end
         end
         ST_WAIT_BR: begin
            stall_w = 1'b1;
            if (bus.cmp_valid) begin
               pc_change_d = br_taken(br_q, bus.ALUCompare);
               state_d     = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase
   end

   logic                  ctrl_valid_q, rst_rf_q, rst_mem_q, rf_rd_q, rf_wr_q, mem_rd_q, mem_wr_q;
   logic                  sel_a_q, sel_b_q;
   logic [1:0]            comp_q;
   logic [REG_ADDR_W-1:0] tgt_q, src_a_q, src_b_q;
   logic [IMM_W-1:0]      imm_q;

   // Control bundle: strobes live one cycle per accept, fields hold until next accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_valid_q <= 1'b0;
         rst_rf_q     <= 1'b0;
         rst_mem_q    <= 1'b0;
         rf_rd_q      <= 1'b0;
         rf_wr_q      <= 1'b0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         sel_a_q      <= 1'b0;
         sel_b_q      <= 1'b0;
         comp_q       <= '0;
         tgt_q        <= '0;
         src_a_q      <= '0;
         src_b_q      <= '0;
         imm_q        <= '0;
      end else begin
         ctrl_valid_q <= accept_w;
         rst_rf_q     <= accept_w && (op_w == OP_RST_RF);
         rf_wr_q      <= accept_w && (op_w == OP_LOAD);
         mem_rd_q     <= accept_w && (op_w == OP_LOAD);
         rf_rd_q      <= accept_w && (op_w == OP_STORE);
         mem_wr_q     <= accept_w && (op_w == OP_STORE);
         rst_mem_q    <= accept_w && (op_w == OP_RST_MEM);
         if (accept_w) begin
            sel_a_q <= sel_a_w;
            sel_b_q <= sel_b_w;
            comp_q  <= (br_w != BR_NONE) ? COMP_CMP : comp_w;
            tgt_q   <= tgt_w;
            src_a_q <= src_a_w;
            src_b_q <= src_b_w;
            imm_q   <= bus.instr[IMM_W-1:0];
         end
      end
   end

   assign bus.instr_ready       = instr_ready_w;
   assign bus.stall             = stall_w;
   assign bus.ctrl_valid        = ctrl_valid_q;
   assign bus.resetRegisterFile = rst_rf_q;
   assign bus.resetMemory       = rst_mem_q;
   assign bus.registerFileRead  = rf_rd_q;
   assign bus.registerFileWrite = rf_wr_q;
   assign bus.memoryRead        = mem_rd_q;
   assign bus.memoryWrite       = mem_wr_q;
   assign bus.sourceSelectA     = sel_a_q;
   assign bus.sourceSelectB     = sel_b_q;
   assign bus.computationSelect = comp_q;
   assign bus.target            = tgt_q;
   assign bus.sourceA           = src_a_q;
   assign bus.sourceB           = src_b_q;
   assign bus.immediate         = imm_q;
   assign bus.PCChangeEnable    = pc_change_q;

`ifdef DPC_PERF_COUNT_EN
   logic [31:0] issued_count_q, stall_count_q;

   // Free-running wrap-around performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_count_q <= '0;
         stall_count_q  <= '0;
      end else begin
         if (accept_w) issued_count_q <= issued_count_q + 32'd1;
         if (stall_w && bus.instr_valid) stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign issued_count = issued_count_q;
   assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_pipelined_datapath_controller.sv
// Directed bench for pipelined_datapath_controller (REG_ADDR_W=8, IMM_W=32,
// WB_LATENCY=3). Build with DPC_PERF_COUNT_EN to also cover the counters.
module tb_pipelined_datapath_controller;

   logic clk;
   logic reset;
   int unsigned total;
   int unsigned passed;

   dpc_if #(.REG_ADDR_W(8), .IMM_W(32)) bus ();

`ifdef DPC_PERF_COUNT_EN
   logic [31:0] issued_count, stall_count;
`endif

   pipelined_datapath_controller #(.REG_ADDR_W(8), .IMM_W(32), .WB_LATENCY(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DPC_PERF_COUNT_EN
      ,
      .issued_count (issued_count),
      .stall_count  (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(logic [1:0] op, logic sa, logic sb, logic [1:0] comp,
                                      logic [1:0] br, logic [7:0] t, logic [7:0] a,
                                      logic [7:0] b, logic [31:0] imm);
      return {op, sa, sb, comp, br, t, a, b, imm};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(logic [63:0] w);
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      #1;
   endtask

   task automatic idle();
      bus.instr_valid = 1'b0;
      #1;
   endtask

   initial begin
      total = 0;
      passed = 0;
      reset = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.cmp_valid   = 1'b0;
      bus.ALUCompare  = 2'b00;
      #3;
      chk("rst_ctrl_valid", bus.ctrl_valid, 0);
      chk("rst_ready", bus.instr_ready, 0);
      chk("rst_stall", bus.stall, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("ready_after_release", bus.instr_ready, 1);

      // load r5, then a store reading r5 as operand A
      offer(mk(2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 8'd5, 8'd1, 8'd2, 32'h1234));
      chk("ld_ready", bus.instr_ready, 1);
      tick();
      chk("ld_ctrl_valid", bus.ctrl_valid, 1);
      chk("ld_rfw", bus.registerFileWrite, 1);
      chk("ld_memrd", bus.memoryRead, 1);
      chk("ld_rfr", bus.registerFileRead, 0);
      chk("ld_target", bus.target, 5);
      chk("ld_imm", bus.immediate, 64'h1234);
      chk("ld_comp", bus.computationSelect, 0);
      offer(mk(2'b10, 1'b0, 1'b1, 2'b01, 2'b11, 8'd7, 8'd5, 8'd9, 32'hAB));
      for (int i = 0; i < 3; i++) begin
         chk("lu_stall", bus.stall, 1);
         chk("lu_ready", bus.instr_ready, 0);
         tick();
      end
      chk("lu_stall_end", bus.stall, 0);
      chk("lu_ready_end", bus.instr_ready, 1);
      chk("lu_bubble", bus.ctrl_valid, 0);
      tick();
      chk("st_ctrl_valid", bus.ctrl_valid, 1);
      chk("st_rfr", bus.registerFileRead, 1);
      chk("st_memwr", bus.memoryWrite, 1);
      chk("st_rfw", bus.registerFileWrite, 0);
      chk("st_srca", bus.sourceA, 5);
      chk("st_srcb", bus.sourceB, 9);
      chk("st_sela", bus.sourceSelectA, 0);
      chk("st_selb", bus.sourceSelectB, 1);
      chk("st_comp", bus.computationSelect, 2'b01);
`ifdef DPC_PERF_COUNT_EN
      chk("perf_issued", issued_count, 2);
      chk("perf_stall", stall_count, 3);
`endif
      idle();
      tick();
      chk("one_cycle_valid", bus.ctrl_valid, 0);
      chk("strobe_clear", bus.memoryWrite, 0);
      chk("field_hold", bus.sourceA, 5);

      // same pair with immediate operand A: no stall
      offer(mk(2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 8'd5, 8'd1, 8'd2, 32'h0));
      tick();
      chk("b2b_first", bus.ctrl_valid, 1);
      offer(mk(2'b10, 1'b1, 1'b1, 2'b01, 2'b11, 8'd7, 8'd5, 8'd9, 32'h0));
      chk("imm_no_stall", bus.stall, 0);
      chk("imm_ready", bus.instr_ready, 1);
      tick();
      chk("b2b_second", bus.ctrl_valid, 1);
      chk("b2b_sela", bus.sourceSelectA, 1);
      idle();
      tick();
      tick();
      tick();

      // branch EQ, compare equal two cycles later, new instruction offered alongside
      offer(mk(2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 32'h0));
      tick();
      chk("br_ctrl_valid", bus.ctrl_valid, 1);
      chk("br_rstmem", bus.resetMemory, 1);
      chk("br_comp", bus.computationSelect, 2'b10);
      chk("br_no_pc_yet", bus.PCChangeEnable, 0);
      idle();
      chk("wait_stall", bus.stall, 1);
      chk("wait_ready", bus.instr_ready, 0);
      tick();
      chk("wait_stall2", bus.stall, 1);
      tick();
      bus.cmp_valid  = 1'b1;
      bus.ALUCompare = 2'b00;
      offer(mk(2'b10, 1'b1, 1'b1, 2'b01, 2'b11, 8'd3, 8'd4, 8'd6, 32'h0));
      chk("simul_ready", bus.instr_ready, 0);
      tick();
      chk("eq_taken", bus.PCChangeEnable, 1);
      chk("simul_not_accepted", bus.ctrl_valid, 0);
      bus.cmp_valid = 1'b0;
      #1;
      chk("simul_ready_next", bus.instr_ready, 1);
      tick();
      chk("simul_accepted", bus.ctrl_valid, 1);
      chk("nb_comp", bus.computationSelect, 2'b01);
      chk("pc_one_cycle", bus.PCChangeEnable, 0);
      idle();
      chk("nb_no_wait", bus.stall, 0);

      // branch EQ, compare greater: not taken
      offer(mk(2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 32'h0));
      tick();
      idle();
      tick();
      bus.cmp_valid  = 1'b1;
      bus.ALUCompare = 2'b10;
      tick();
      chk("eq_not_taken", bus.PCChangeEnable, 0);
      chk("back_to_issue", bus.instr_ready, 1);
      bus.ALUCompare = 2'b00;
      tick();
      chk("cmp_in_issue", bus.PCChangeEnable, 0);
      bus.cmp_valid = 1'b0;

      // branch GT, compare greater: taken
      offer(mk(2'b11, 1'b1, 1'b1, 2'b00, 2'b01, 8'd0, 8'd0, 8'd0, 32'h0));
      tick();
      idle();
      bus.cmp_valid  = 1'b1;
      bus.ALUCompare = 2'b10;
      tick();
      chk("gt_taken", bus.PCChangeEnable, 1);
      bus.cmp_valid = 1'b0;
      tick();

      // reset-RF issue flushes a pending r5 write
      offer(mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b11, 8'd5, 8'd0, 8'd0, 32'h0));
      tick();
      offer(mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b11, 8'd0, 8'd0, 8'd0, 32'h0));
      chk("flush_op_ready", bus.instr_ready, 1);
      tick();
      chk("flush_rstrf", bus.resetRegisterFile, 1);
      chk("flush_rfw", bus.registerFileWrite, 0);
      offer(mk(2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 8'd1, 8'd5, 8'd0, 32'h0));
      chk("flush_no_stall", bus.stall, 0);
      chk("flush_ready", bus.instr_ready, 1);
      tick();
      chk("flush_reader_valid", bus.ctrl_valid, 1);
      chk("flush_reader_memwr", bus.memoryWrite, 1);
      idle();
      tick();

      // reset while waiting on a branch that would be taken
      offer(mk(2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 8'd9, 8'd0, 8'd0, 32'hFFFF));
      tick();
      chk("pre_rst_target", bus.target, 9);
      reset          = 1'b1;
      bus.cmp_valid  = 1'b1;
      bus.ALUCompare = 2'b00;
      idle();
      chk("mid_rst_ctrl_valid", bus.ctrl_valid, 0);
      chk("mid_rst_rstmem", bus.resetMemory, 0);
      chk("mid_rst_target", bus.target, 0);
      chk("mid_rst_imm", bus.immediate, 0);
      chk("mid_rst_stall", bus.stall, 0);
      chk("mid_rst_ready", bus.instr_ready, 0);
      tick();
      chk("mid_rst_no_pc", bus.PCChangeEnable, 0);
`ifdef DPC_PERF_COUNT_EN
      chk("perf_rst_issued", issued_count, 0);
      chk("perf_rst_stall", stall_count, 0);
`endif
      reset = 1'b0;
      bus.cmp_valid = 1'b0;
      #1;
      chk("post_rst_ready", bus.instr_ready, 1);
      chk("post_rst_stall", bus.stall, 0);
      tick();
      chk("post_rst_no_pc", bus.PCChangeEnable, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
